// File: rtl/frame_ring_ctrl.sv
// frame_ring_ctrl: manages a ring of NUM_BUFS frame slots between a sensor-driven
// DMA writer and a single reader.
//   clk, rst_n            : clock, asynchronous active-low reset
//   enable, frame_sync    : capture enable level, start-of-frame pulse
//   dma_start/base/len    : DMA request (one-cycle start, slot address, length)
//   dma_done              : DMA end-of-transfer pulse
//   rd_valid/base/locked  : oldest committed frame and its claim status
//   rd_take, rd_release   : reader claims / frees the oldest frame
//   buf_count             : committed frames held
//   overwrite, frame_drop : event pulses; busy high in RUN or COMMIT
module frame_ring_ctrl #(
  parameter int unsigned NUM_BUFS  = 4,
  parameter logic [15:0] BUF_BYTES = 16'h1000,
  parameter logic [15:0] BASE_ADDR = 16'h8000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic                              frame_sync,
  output logic                              dma_start,
  output logic [15:0]                       dma_base,
  output logic [15:0]                       dma_len,
  input  logic                              dma_done,
  output logic                              rd_valid,
  output logic [15:0]                       rd_base,
  input  logic                              rd_take,
  input  logic                              rd_release,
  output logic                              rd_locked,
  output logic [$clog2(NUM_BUFS+1)-1:0]     buf_count,
  output logic                              overwrite,
  output logic                              frame_drop,
  output logic                              busy
);

  localparam int unsigned PTR_W = $clog2(NUM_BUFS);
  localparam int unsigned CNT_W = $clog2(NUM_BUFS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BUFS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    RUN      = 2'd2,
    COMMIT   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               locked_q, locked_d;
  logic               dma_start_q, dma_start_d;
  logic [15:0]        dma_base_q, dma_base_d;
  logic [15:0]        dma_len_q;
  logic               rd_valid_q, rd_valid_d;
  logic [15:0]        rd_base_q, rd_base_d;
  logic               overwrite_q, overwrite_d;
  logic               frame_drop_q, frame_drop_d;
  logic               busy_q, busy_d;
  logic               push, pop, full, take_ok, rel_ok;

  // Slot base address, wrapping modulo 2^16.
  function automatic logic [15:0] slot_addr(input logic [PTR_W-1:0] ptr);
    return 16'(32'(BASE_ADDR) + 32'(ptr) * 32'(BUF_BYTES));
  endfunction

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      locked_q     <= 1'b0;
      dma_start_q  <= 1'b0;
      dma_base_q   <= BASE_ADDR;
      dma_len_q    <= BUF_BYTES;
      rd_valid_q   <= 1'b0;
      rd_base_q    <= BASE_ADDR;
      overwrite_q  <= 1'b0;
      frame_drop_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      locked_q     <= locked_d;
      dma_start_q  <= dma_start_d;
      dma_base_q   <= dma_base_d;
      dma_len_q    <= BUF_BYTES;
      rd_valid_q   <= rd_valid_d;
      rd_base_q    <= rd_base_d;
      overwrite_q  <= overwrite_d;
      frame_drop_q <= frame_drop_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state, ring bookkeeping and registered-output inputs.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    locked_d     = locked_q;
    dma_start_d  = 1'b0;
    dma_base_d   = dma_base_q;
    overwrite_d  = 1'b0;
    frame_drop_d = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    full         = (count_q == FULL_CNT);
    take_ok      = rd_take && (count_q != '0) && !locked_q;
    rel_ok       = rd_release && locked_q;

    case (state_q)
      IDLE: begin
        if (enable) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (frame_sync) begin
          if (full && locked_q) begin
            // Only free slot is held by the reader: nowhere to write.
            frame_drop_d = 1'b1;
          end else begin
            state_d     = RUN;
            dma_start_d = 1'b1;
            dma_base_d  = slot_addr(wr_ptr_q);
            if (full) begin
              // Recycle the oldest unlocked frame for the new capture.
              overwrite_d = 1'b1;
              pop         = 1'b1;
            end
          end
        end
      end
      RUN: begin
        frame_drop_d = frame_sync;
        if (dma_done) state_d = COMMIT;
      end
      COMMIT: begin
        // A frame arriving while committing cannot be captured either.
        frame_drop_d = frame_sync;
        push         = 1'b1;
        state_d      = enable ? WAIT_SOF : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reader claim/free; release and overwrite are mutually exclusive via lock.
    if (take_ok) locked_d = 1'b1;
    if (rel_ok) begin
      locked_d = 1'b0;
      pop      = 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    rd_valid_d = (count_d != '0);
    rd_base_d  = slot_addr(rd_ptr_d);
    busy_d     = (state_d == RUN) || (state_d == COMMIT);
  end

  assign dma_start  = dma_start_q;
  assign dma_base   = dma_base_q;
  assign dma_len    = dma_len_q;
  assign rd_valid   = rd_valid_q;
  assign rd_base    = rd_base_q;
  assign rd_locked  = locked_q;
  assign buf_count  = count_q;
  assign overwrite  = overwrite_q;
  assign frame_drop = frame_drop_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_frame_ring_ctrl.sv
// Bench for frame_ring_ctrl: a queue-based ring model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_frame_ring_ctrl;

  localparam int unsigned N  = 4;
  localparam logic [15:0] BB = 16'h1000;
  localparam logic [15:0] BA = 16'h8000;
  localparam int unsigned CW = $clog2(N + 1);

  logic          clk, rst_n, enable, frame_sync, dma_done, rd_take, rd_release;
  logic          dma_start, rd_valid, rd_locked, overwrite, frame_drop, busy;
  logic [15:0]   dma_base, dma_len, rd_base;
  logic [CW-1:0] buf_count;

  int n_checks = 0;
  int n_fail   = 0;

  frame_ring_ctrl #(.NUM_BUFS(N), .BUF_BYTES(BB), .BASE_ADDR(BA)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_sync(frame_sync),
    .dma_start(dma_start), .dma_base(dma_base), .dma_len(dma_len),
    .dma_done(dma_done), .rd_valid(rd_valid), .rd_base(rd_base),
    .rd_take(rd_take), .rd_release(rd_release), .rd_locked(rd_locked),
    .buf_count(buf_count), .overwrite(overwrite), .frame_drop(frame_drop),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_ARMED, M_CAPTURE, M_COMMIT} mphase_e;
  mphase_e     ph      = M_IDLE;
  logic [15:0] ring[$];            // committed frame addresses, oldest first
  int          wr_slot = 0;        // slot the next capture lands in
  bit          m_lock  = 1'b0;
  bit          e_start = 1'b0, e_ovw = 1'b0, e_drop = 1'b0;
  logic [15:0] m_base  = BA;

  function automatic logic [15:0] addr_of(input int slot);
    return 16'(32'(BA) + 32'(slot) * 32'(BB));
  endfunction

  // With no committed frames the oldest slot coincides with the write slot.
  function automatic logic [15:0] exp_rd_base();
    return (ring.size() > 0) ? ring[0] : addr_of(wr_slot);
  endfunction

  initial begin : model
    bit tk, rl;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        ph = M_IDLE; ring.delete(); wr_slot = 0; m_lock = 1'b0;
        e_start = 1'b0; e_ovw = 1'b0; e_drop = 1'b0; m_base = BA;
      end else begin
        tk = rd_take && (ring.size() > 0) && !m_lock;
        rl = rd_release && m_lock;
        e_start = 1'b0; e_ovw = 1'b0; e_drop = 1'b0;
        case (ph)
          M_IDLE: if (enable) ph = M_ARMED;
          M_ARMED: begin
            if (!enable) ph = M_IDLE;
            else if (frame_sync) begin
              if (ring.size() == N && m_lock) e_drop = 1'b1;
              else begin
                if (ring.size() == N) begin
                  void'(ring.pop_front());
                  e_ovw = 1'b1;
                end
                e_start = 1'b1;
                m_base  = addr_of(wr_slot);
                ph      = M_CAPTURE;
              end
            end
          end
          M_CAPTURE: begin
            if (frame_sync) e_drop = 1'b1;
            if (dma_done) ph = M_COMMIT;
          end
          M_COMMIT: begin
            if (frame_sync) e_drop = 1'b1;
            ring.push_back(addr_of(wr_slot));
            wr_slot = (wr_slot + 1) % N;
            ph = enable ? M_ARMED : M_IDLE;
          end
          default: ph = M_IDLE;
        endcase
        if (rl) begin
          void'(ring.pop_front());
          m_lock = 1'b0;
        end
        if (tk) m_lock = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      chk("dma_start",  32'(dma_start),  32'(e_start));
      chk("dma_base",   32'(dma_base),   32'(m_base));
      chk("dma_len",    32'(dma_len),    32'(BB));
      chk("rd_valid",   32'(rd_valid),   32'(ring.size() != 0));
      chk("rd_base",    32'(rd_base),    32'(exp_rd_base()));
      chk("rd_locked",  32'(rd_locked),  32'(m_lock));
      chk("buf_count",  32'(buf_count),  32'(ring.size()));
      chk("overwrite",  32'(overwrite),  32'(e_ovw));
      chk("frame_drop", 32'(frame_drop), 32'(e_drop));
      chk("busy",       32'(busy),       32'(ph == M_CAPTURE || ph == M_COMMIT));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic reset_check();
    chk("rst_dma_start",  32'(dma_start),  32'd0);
    chk("rst_dma_base",   32'(dma_base),   32'h8000);
    chk("rst_dma_len",    32'(dma_len),    32'h1000);
    chk("rst_rd_valid",   32'(rd_valid),   32'd0);
    chk("rst_rd_base",    32'(rd_base),    32'h8000);
    chk("rst_rd_locked",  32'(rd_locked),  32'd0);
    chk("rst_buf_count",  32'(buf_count),  32'd0);
    chk("rst_overwrite",  32'(overwrite),  32'd0);
    chk("rst_frame_drop", 32'(frame_drop), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
  endtask

  // One full capture: sync, check request, done, commit; ends after commit.
  task automatic frame(input logic [31:0] exp_base);
    @(negedge clk); frame_sync = 1'b1;
    @(negedge clk); frame_sync = 1'b0;
    chk("frm_dma_start", 32'(dma_start), 32'd1);
    chk("frm_dma_base",  32'(dma_base),  exp_base);
    chk("frm_overwrite", 32'(overwrite), 32'd0);
    dma_done = 1'b1;
    @(negedge clk); dma_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stim
    rst_n = 1'b0; enable = 1'b0; frame_sync = 1'b0; dma_done = 1'b0;
    rd_take = 1'b0; rd_release = 1'b0;
    repeat (3) @(negedge clk);
    reset_check();

    // Sync in the first cycle out of reset is not honoured.
    rst_n = 1'b1; enable = 1'b1; frame_sync = 1'b1;
    @(negedge clk); frame_sync = 1'b0;
    chk("early_sync_start", 32'(dma_start),  32'd0);
    chk("early_sync_drop",  32'(frame_drop), 32'd0);

    // Fill the ring.
    frame(32'h8000); frame(32'h9000); frame(32'hA000); frame(32'hB000);
    chk("fill_count",   32'(buf_count), 32'd4);
    chk("fill_rd_base", 32'(rd_base),   32'h8000);
    chk("fill_valid",   32'(rd_valid),  32'd1);

    // Full and unlocked: overwrite oldest alongside the start.
    @(negedge clk); frame_sync = 1'b1;
    @(negedge clk); frame_sync = 1'b0;
    chk("ovw_start",   32'(dma_start), 32'd1);
    chk("ovw_pulse",   32'(overwrite), 32'd1);
    chk("ovw_base",    32'(dma_base),  32'h8000);
    chk("ovw_rd_base", 32'(rd_base),   32'h9000);
    chk("ovw_count",   32'(buf_count), 32'd3);
    dma_done = 1'b1;
    @(negedge clk); dma_done = 1'b0;
    @(negedge clk);
    chk("ovw_count_after", 32'(buf_count), 32'd4);

    // Reset in the middle of a transfer.
    @(negedge clk); frame_sync = 1'b1;
    @(negedge clk); frame_sync = 1'b0;
    chk("midrun_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 reset_check();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_start", 32'(dma_start), 32'd0);
    chk("post_rst_count", 32'(buf_count), 32'd0);
    frame(32'h8000); frame(32'h9000); frame(32'hA000); frame(32'hB000);

    // Full and locked: sync dropped.
    rd_take = 1'b1;
    @(negedge clk); rd_take = 1'b0;
    chk("take_locked", 32'(rd_locked), 32'd1);
    frame_sync = 1'b1;
    @(negedge clk); frame_sync = 1'b0;
    chk("lock_drop",    32'(frame_drop), 32'd1);
    chk("lock_start",   32'(dma_start),  32'd0);
    chk("lock_count",   32'(buf_count),  32'd4);
    chk("lock_rd_base", 32'(rd_base),    32'h8000);
    rd_release = 1'b1;
    @(negedge clk); rd_release = 1'b0;
    chk("rel_locked",  32'(rd_locked), 32'd0);
    chk("rel_count",   32'(buf_count), 32'd3);
    chk("rel_rd_base", 32'(rd_base),   32'h9000);

    // Bring count to 2, lock oldest, then release in the commit cycle.
    rd_take = 1'b1;
    @(negedge clk); rd_take = 1'b0; rd_release = 1'b1;
    @(negedge clk); rd_release = 1'b0;
    chk("two_count",   32'(buf_count), 32'd2);
    chk("two_rd_base", 32'(rd_base),   32'hA000);
    rd_take = 1'b1;
    @(negedge clk); rd_take = 1'b0; frame_sync = 1'b1;
    @(negedge clk); frame_sync = 1'b0;
    chk("cr_base", 32'(dma_base), 32'h8000);
    dma_done = 1'b1;
    @(negedge clk); dma_done = 1'b0; rd_release = 1'b1;
    @(negedge clk); rd_release = 1'b0;
    chk("cr_count",   32'(buf_count), 32'd2);
    chk("cr_rd_base", 32'(rd_base),   32'hB000);

    // Sync and disable during a transfer.
    frame_sync = 1'b1;
    @(negedge clk); frame_sync = 1'b0;
    chk("run_base", 32'(dma_base), 32'h9000);
    frame_sync = 1'b1; enable = 1'b0;
    @(negedge clk); frame_sync = 1'b0;
    chk("run_drop",  32'(frame_drop), 32'd1);
    chk("run_start", 32'(dma_start),  32'd0);
    chk("run_busy",  32'(busy),       32'd1);
    dma_done = 1'b1;
    @(negedge clk); dma_done = 1'b0;
    chk("commit_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("idle_busy",  32'(busy),      32'd0);
    chk("idle_count", 32'(buf_count), 32'd3);
    frame_sync = 1'b1;
    @(negedge clk); frame_sync = 1'b0;
    chk("idle_sync_start", 32'(dma_start),  32'd0);
    chk("idle_sync_drop",  32'(frame_drop), 32'd0);
    enable = 1'b1;

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      enable     = ($urandom_range(0, 19) != 0);
      frame_sync = ($urandom_range(0, 5) == 0);
      dma_done   = ($urandom_range(0, 3) == 0);
      rd_take    = ($urandom_range(0, 4) == 0);
      rd_release = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #1 reset_check();
        @(negedge clk); rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
